// File: rtl/cos_sine_quad_reconst_pipe.sv
// -----------------------------------------------------------------------------
// cos_sine_quad_reconst_pipe
//
// Rebuilds full-circle cos/sin values from first-quadrant magnitudes produced
// by the quarter-wave LUT/CORDIC stage. It feeds the mixer/DAC formatter.
//
//   Stage 1 (S1): picks the swap and sign for the quadrant and captures the
//                 format select and quadrant tag.
//   Stage 2 (S2): converts each (sign, magnitude) pair into the requested
//                 output format and drives the registered outputs.
//
// Flow control is valid/ready with full backpressure. A full pipeline still
// accepts a new sample in the same cycle that the downstream takes one, so
// throughput is one sample per clock.
//
// Parameters
//   WIDTH     magnitude width of iCos/iSin; the outputs are WIDTH+1 bits wide
//   ZERO_POS  1: a sign-magnitude zero is always emitted as +0
//             0: the sign bit selected for the quadrant is kept as-is
//
// Ports
//   iClk    in   1        clock, rising edge
//   iRst    in   1        synchronous, active-high reset
//   iValid  in   1        input sample valid
//   oReady  out  1        the block can accept an input this cycle
//   iQuad   in   2        quadrant of the full angle (0..3)
//   iCos    in   WIDTH    unsigned cos magnitude of the in-quadrant angle
//   iSin    in   WIDTH    unsigned sin magnitude of the in-quadrant angle
//   iFmt    in   1        0: sign-magnitude {sign,mag}; 1: two's complement
//   oValid  out  1        output sample valid
//   iReady  in   1        downstream accepts the output this cycle
//   oCos    out  WIDTH+1  reconstructed cos
//   oSin    out  WIDTH+1  reconstructed sin
//   oQuad   out  2        iQuad of the sample on the outputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cos_sine_quad_reconst_pipe #(
  parameter int WIDTH    = 16,
  parameter int ZERO_POS = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [1:0]       iQuad,
  input  logic [WIDTH-1:0] iCos,
  input  logic [WIDTH-1:0] iSin,
  input  logic             iFmt,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH:0]   oCos,
  output logic [WIDTH:0]   oSin,
  output logic [1:0]       oQuad
);

  localparam logic [WIDTH:0]   ONE_W1  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_W1 = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  // ---------------------------------------------------------------------------
  // Format conversion for one (sign, magnitude) pair.
  // Two's complement: negating {0,mag} cannot overflow WIDTH+1 bits, so a
  // full-scale magnitude needs no saturation. A negated zero wraps back to 0.
  // Sign-magnitude: the sign bit may be forced to + when the magnitude is 0.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH:0] format_sample(
    input logic             neg,
    input logic [WIDTH-1:0] mag,
    input logic             fmt
  );
    logic [WIDTH:0] ext;
    logic [WIDTH:0] result;
    logic           sign;
    ext = {1'b0, mag};
    if (fmt) begin
      if (neg) begin
        result = ~ext + ONE_W1;
      end else begin
        result = ext;
      end
    end else begin
      if ((ZERO_POS != 0) && (mag == ZERO_W)) begin
        sign = 1'b0;
      end else begin
        sign = neg;
      end
      result = {sign, mag};
    end
    return result;
  endfunction

  // Handshake and pipeline-control signals
  logic             in_xfer_s;
  logic             move_s;

  // Quadrant-resolved (sign, magnitude) pairs, before registering into S1
  logic             sel_cos_neg_s;
  logic             sel_sin_neg_s;
  logic [WIDTH-1:0] sel_cos_mag_s;
  logic [WIDTH-1:0] sel_sin_mag_s;

  // Stage 1 registers
  logic             v1_r;
  logic             s1_cos_neg_r;
  logic             s1_sin_neg_r;
  logic [WIDTH-1:0] s1_cos_mag_r;
  logic [WIDTH-1:0] s1_sin_mag_r;
  logic             s1_fmt_r;
  logic [1:0]       s1_quad_r;

  // Stage 2 registers, which are also the outputs
  logic             v2_r;
  logic [WIDTH:0]   cos_r;
  logic [WIDTH:0]   sin_r;
  logic [1:0]       quad_r;

  // Ready depends only on pipeline occupancy and downstream ready.
  // It never depends on iValid, so there is no combinational loop upstream.
  always_comb begin
    oReady    = !v1_r || !v2_r || iReady;
    in_xfer_s = iValid && oReady;
    // S1 advances whenever S2 is empty or is being emptied this cycle.
    move_s    = v1_r && (!v2_r || iReady);
  end

  // Quadrant reconstruction: rotate (+C, +S) by quad * 90 degrees.
  always_comb begin
    sel_cos_neg_s = 1'b0;
    sel_sin_neg_s = 1'b0;
    sel_cos_mag_s = iCos;
    sel_sin_mag_s = iSin;
    case (iQuad)
      2'd0: begin
        sel_cos_neg_s = 1'b0;
        sel_cos_mag_s = iCos;
        sel_sin_neg_s = 1'b0;
        sel_sin_mag_s = iSin;
      end
      2'd1: begin
        sel_cos_neg_s = 1'b1;
        sel_cos_mag_s = iSin;
        sel_sin_neg_s = 1'b0;
        sel_sin_mag_s = iCos;
      end
      2'd2: begin
        sel_cos_neg_s = 1'b1;
        sel_cos_mag_s = iCos;
        sel_sin_neg_s = 1'b1;
        sel_sin_mag_s = iSin;
      end
      2'd3: begin
        sel_cos_neg_s = 1'b0;
        sel_cos_mag_s = iSin;
        sel_sin_neg_s = 1'b1;
        sel_sin_mag_s = iCos;
      end
      default: begin
        sel_cos_neg_s = 1'b0;
        sel_cos_mag_s = iCos;
        sel_sin_neg_s = 1'b0;
        sel_sin_mag_s = iSin;
      end
    endcase
  end

  // Stage 1: capture the quadrant-resolved sample on an input transfer.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      v1_r         <= 1'b0;
      s1_cos_neg_r <= 1'b0;
      s1_sin_neg_r <= 1'b0;
      s1_cos_mag_r <= ZERO_W;
      s1_sin_mag_r <= ZERO_W;
      s1_fmt_r     <= 1'b0;
      s1_quad_r    <= 2'd0;
    end else begin
      v1_r <= in_xfer_s || (v1_r && !move_s);
      if (in_xfer_s) begin
        s1_cos_neg_r <= sel_cos_neg_s;
        s1_sin_neg_r <= sel_sin_neg_s;
        s1_cos_mag_r <= sel_cos_mag_s;
        s1_sin_mag_r <= sel_sin_mag_s;
        s1_fmt_r     <= iFmt;
        s1_quad_r    <= iQuad;
      end
    end
  end

  // Stage 2: format conversion into the output registers. Outputs hold while stalled.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      v2_r   <= 1'b0;
      cos_r  <= ZERO_W1;
      sin_r  <= ZERO_W1;
      quad_r <= 2'd0;
    end else begin
      v2_r <= move_s || (v2_r && !iReady);
      if (move_s) begin
        cos_r  <= format_sample(s1_cos_neg_r, s1_cos_mag_r, s1_fmt_r);
        sin_r  <= format_sample(s1_sin_neg_r, s1_sin_mag_r, s1_fmt_r);
        quad_r <= s1_quad_r;
      end
    end
  end

  // Outputs come straight from the stage 2 registers.
  always_comb begin
    oValid = v2_r;
    oCos   = cos_r;
    oSin   = sin_r;
    oQuad  = quad_r;
  end

endmodule

// File: tb/tb_cos_sine_quad_reconst_pipe.sv
`timescale 1ns/1ps

module tb_cos_sine_quad_reconst_pipe;

  logic        iClk = 1'b0;
  logic        iRst, iValid, iFmt, iReady;
  logic [1:0]  iQuad;
  logic [15:0] iCos, iSin;
  logic        oReady, oValid, oReady_z, oValid_z;
  logic [16:0] oCos, oSin, oCos_z, oSin_z;
  logic [1:0]  oQuad, oQuad_z;

  int n_vec = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];

  cos_sine_quad_reconst_pipe #(.WIDTH(16), .ZERO_POS(1)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iQuad(iQuad),
    .iCos(iCos), .iSin(iSin), .iFmt(iFmt), .oValid(oValid), .iReady(iReady),
    .oCos(oCos), .oSin(oSin), .oQuad(oQuad));

  cos_sine_quad_reconst_pipe #(.WIDTH(16), .ZERO_POS(0)) dut_zp0 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady_z), .iQuad(iQuad),
    .iCos(iCos), .iSin(iSin), .iFmt(iFmt), .oValid(oValid_z), .iReady(iReady),
    .oCos(oCos_z), .oSin(oSin_z), .oQuad(oQuad_z));

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encode a signed quantity (sign flag + integer magnitude) into the output format.
  function automatic logic [16:0] encode(input logic neg, input int mag, input logic fmt, input int zp);
    int v;
    logic [31:0] w;
    if (fmt) begin
      v = neg ? -mag : mag;
      w = v;
      return w[16:0];
    end else begin
      w = mag;
      return {neg && !(zp != 0 && mag == 0), w[15:0]};
    end
  endfunction

  // Reference: rotate the vector (+C, +S) by q quarter turns, (x, y) -> (-y, x).
  function automatic logic [35:0] ref_model(input logic [1:0] q, input logic [15:0] c,
                                            input logic [15:0] s, input logic f, input int zp);
    logic xn, yn, tn;
    int xm, ym, tm;
    xn = 1'b0; xm = int'(c);
    yn = 1'b0; ym = int'(s);
    for (int k = 0; k < int'(q); k++) begin
      tn = xn; tm = xm;
      xn = !yn; xm = ym;
      yn = tn;  ym = tm;
    end
    return {q, encode(xn, xm, f, zp), encode(yn, ym, f, zp)};
  endfunction

  function automatic logic [15:0] rnd_mag();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  task automatic test_reset();
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
    @(negedge iClk); @(negedge iClk);
    iRst = 1'b0;
    #1;
    n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid: got %b want 0", oValid); end
    n_vec++; if (oCos !== 17'h00000) begin n_bad++; $display("FAIL reset_ocos: got %h want 00000", oCos); end
    n_vec++; if (oSin !== 17'h00000) begin n_bad++; $display("FAIL reset_osin: got %h want 00000", oSin); end
    n_vec++; if (oQuad !== 2'd0) begin n_bad++; $display("FAIL reset_oquad: got %0d want 0", oQuad); end
    n_vec++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL reset_oready: got %b want 1", oReady); end
    @(negedge iClk);
  endtask

  task automatic test_directed();
    logic [1:0]  q_t[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic        f_t[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] c_t[4]  = '{16'h7000, 16'h0100, 16'h0000, 16'hFFFF};
    logic [15:0] s_t[4]  = '{16'h1234, 16'h0001, 16'h0005, 16'h8000};
    logic [16:0] ec_t[4] = '{17'h07000, 17'h1FFFF, 17'h00000, 17'h08000};
    logic [16:0] es_t[4] = '{17'h01234, 17'h00100, 17'h10005, 17'h10001};
    for (int i = 0; i < 4; i++) begin
      iValid = 1'b1; iReady = 1'b1;
      iQuad = q_t[i]; iFmt = f_t[i]; iCos = c_t[i]; iSin = s_t[i];
      #1;
      n_vec++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL dir%0d_oready: got %b want 1", i, oReady); end
      @(negedge iClk);
      iValid = 1'b0;
      n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, oValid); end
      @(negedge iClk);
      n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_ovalid: got %b want 1", i, oValid); end
      n_vec++; if (oCos !== ec_t[i]) begin n_bad++; $display("FAIL dir%0d_ocos: got %h want %h", i, oCos, ec_t[i]); end
      n_vec++; if (oSin !== es_t[i]) begin n_bad++; $display("FAIL dir%0d_osin: got %h want %h", i, oSin, es_t[i]); end
      n_vec++; if (oQuad !== q_t[i]) begin n_bad++; $display("FAIL dir%0d_oquad: got %0d want %0d", i, oQuad, q_t[i]); end
      if (i == 2) begin
        n_vec++; if (oCos_z !== 17'h10000) begin n_bad++; $display("FAIL zp0_ocos: got %h want 10000", oCos_z); end
        n_vec++; if (oSin_z !== 17'h10005) begin n_bad++; $display("FAIL zp0_osin: got %h want 10005", oSin_z); end
        n_vec++; if (oValid_z !== 1'b1 || oReady_z !== 1'b1 || oQuad_z !== 2'd2) begin
          n_bad++; $display("FAIL zp0_ctl: got v=%b r=%b q=%0d want v=1 r=1 q=2", oValid_z, oReady_z, oQuad_z);
        end
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_sweep();
    logic        hold_prev = 1'b0;
    logic [35:0] prev_out = 36'd0;
    logic [35:0] got, want;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      iValid = ($urandom_range(0, 9) < 7);
      iReady = ($urandom_range(0, 9) < 7);
      iQuad = 2'($urandom_range(0, 3));
      iFmt = 1'($urandom_range(0, 1));
      iCos = rnd_mag();
      iSin = rnd_mag();
      #1;
      got = {oQuad, oCos, oSin};
      if (hold_prev) begin
        n_vec++; if (got !== prev_out) begin n_bad++; $display("FAIL sweep_stall_stable: got %h want %h", got, prev_out); end
      end
      n_vec++;
      if (oReady !== !(exp_q.size() == 2 && !iReady)) begin
        n_bad++; $display("FAIL sweep_oready: got %b want %b", oReady, !(exp_q.size() == 2 && !iReady));
      end
      if (exp_q.size() == 0) begin
        n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL sweep_spurious_valid: got %b want 0", oValid); end
      end
      if (oValid && iReady && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_vec++; if (got !== want) begin n_bad++; $display("FAIL sweep_data: got %h want %h", got, want); end
      end
      if (iValid && oReady) exp_q.push_back(ref_model(iQuad, iCos, iSin, iFmt, 1));
      hold_prev = oValid && !iReady;
      prev_out = got;
      @(negedge iClk);
    end
    iValid = 1'b0; iReady = 1'b1;
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      #1;
      if (oValid) begin
        want = exp_q.pop_front();
        got = {oQuad, oCos, oSin};
        n_vec++; if (got !== want) begin n_bad++; $display("FAIL sweep_drain: got %h want %h", got, want); end
      end
      @(negedge iClk);
    end
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sweep_drain_timeout: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [15:0] sc[6], ss[6];
    logic [1:0]  sq[6];
    logic        sf[6];
    int idx = 0;
    int acc = 0;
    logic [35:0] got, want;
    for (int k = 0; k < 6; k++) begin
      sc[k] = rnd_mag(); ss[k] = rnd_mag();
      sq[k] = 2'($urandom_range(0, 3)); sf[k] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      iValid = 1'b1; iReady = 1'b0;
      iQuad = sq[idx]; iFmt = sf[idx]; iCos = sc[idx]; iSin = ss[idx];
      #1;
      if (c >= 2) begin
        got = {oQuad, oCos, oSin};
        n_vec++; if (oValid !== 1'b1 || got !== exp_q[0]) begin
          n_bad++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", oValid, got, exp_q[0]);
        end
      end
      if (oReady) begin
        exp_q.push_back(ref_model(sq[idx], sc[idx], ss[idx], sf[idx], 1));
        idx++; acc++;
      end
      @(negedge iClk);
    end
    #1;
    n_vec++; if (acc != 2) begin n_bad++; $display("FAIL stall_accept_count: got %0d want 2", acc); end
    n_vec++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL stall_oready: got %b want 0", oReady); end
    for (int c = 0; c < 7; c++) begin
      iValid = (idx < 6); iReady = 1'b1;
      if (idx < 6) begin
        iQuad = sq[idx]; iFmt = sf[idx]; iCos = sc[idx]; iSin = ss[idx];
      end
      #1;
      got = {oQuad, oCos, oSin};
      if (c < 6) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++; $display("FAIL stall_release_empty: got %0d pending want >0", exp_q.size());
        end else begin
          want = exp_q.pop_front();
          n_vec++; if (oValid !== 1'b1 || got !== want) begin
            n_bad++; $display("FAIL stall_release%0d: got v=%b %h want v=1 %h", c, oValid, got, want);
          end
        end
      end else begin
        n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL stall_tail_valid: got %b want 0", oValid); end
      end
      if (iValid && oReady) begin
        exp_q.push_back(ref_model(sq[idx], sc[idx], ss[idx], sf[idx], 1));
        idx++;
      end
      @(negedge iClk);
    end
    n_vec++; if (idx != 6) begin n_bad++; $display("FAIL stall_total_accepted: got %0d want 6", idx); end
    iValid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [35:0] want, got;
    iReady = 1'b0;
    for (int c = 0; c < 2; c++) begin
      iValid = 1'b1; iQuad = 2'($urandom_range(0, 3)); iFmt = 1'b0;
      iCos = rnd_mag(); iSin = rnd_mag();
      @(negedge iClk);
    end
    #1;
    n_vec++; if (oReady !== 1'b0 || oValid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_full: got r=%b v=%b want r=0 v=1", oReady, oValid);
    end
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0; iValid = 1'b0; iReady = 1'b1;
    #1;
    n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL midrst_ovalid: got %b want 0", oValid); end
    n_vec++; if (oCos !== 17'h0 || oSin !== 17'h0 || oQuad !== 2'd0) begin
      n_bad++; $display("FAIL midrst_data: got %h %h %0d want 0 0 0", oCos, oSin, oQuad);
    end
    n_vec++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL midrst_oready: got %b want 1", oReady); end
    iValid = 1'b1; iQuad = 2'($urandom_range(0, 3)); iFmt = 1'b1;
    iCos = rnd_mag(); iSin = rnd_mag();
    want = ref_model(iQuad, iCos, iSin, iFmt, 1);
    @(negedge iClk);
    iValid = 1'b0;
    n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL midrst_early: got %b want 0", oValid); end
    @(negedge iClk);
    got = {oQuad, oCos, oSin};
    n_vec++; if (oValid !== 1'b1 || got !== want) begin
      n_bad++; $display("FAIL midrst_sample: got v=%b %h want v=1 %h", oValid, got, want);
    end
    @(negedge iClk);
  endtask

  initial begin
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b1; iFmt = 1'b0;
    iQuad = 2'd0; iCos = 16'h0000; iSin = 16'h0000;
    test_reset();
    test_directed();
    test_sweep();
    test_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
